// File: rtl/aes_inv_key_schedule.sv
// Inverse AES-128 key schedule: streams round keys Nr..0 from the round-Nr key.
// Build option INV_KEY_SBOX_REG_EN adds a SUBW state that registers the S-box path.
module sub_table (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine map
    always_comb begin : sbox_c
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = in_byte;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        out_byte = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;
    end

endmodule

module aes_inv_key_schedule #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [127:0]   keyIn,
    output logic [127:0]   key_out,
    output logic [3:0]     key_round,
    output logic           key_valid,
    input  logic           key_ready,
    output logic           key_last,
    output logic           busy,
    output logic           done
);

    typedef enum logic [2:0] {
        IDLE,
        EMIT,
        SUBW,
        STEP,
        FIN
    } state_t;

    state_t              state_q, state_d;
    logic [Nk*32-1:0]    cur_q, cur_d;
    logic [3:0]          rnd_q, rnd_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rot, sw;
    logic [7:0]   rcon_v;
    logic [127:0] prev;

`ifdef INV_KEY_SBOX_REG_EN
    logic [31:0]  sub_q, sub_d;
    logic [7:0]   rcon_q, rcon_d;
`endif

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        sub_table u_sbox (
            .in_byte  (rot[8*i +: 8]),
            .out_byte (sw[8*i +: 8])
        );
    end

    // Previous round key from the current one; only w0 needs the S-box
    always_comb begin
        w0     = cur_q[127:96];
        w1     = cur_q[95:64];
        w2     = cur_q[63:32];
        w3     = cur_q[31:0];
        p3     = w3 ^ w2;
        p2     = w2 ^ w1;
        p1     = w1 ^ w0;
        rot    = {p3[23:0], p3[31:24]};
        rcon_v = rcon(rnd_q);
`ifdef INV_KEY_SBOX_REG_EN
        p0     = w0 ^ sub_q ^ {rcon_q, 24'h0};
`else
        p0     = w0 ^ sw ^ {rcon_v, 24'h0};
`endif
        prev   = {p0, p1, p2, p3};
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rnd_d   = rnd_q;
`ifdef INV_KEY_SBOX_REG_EN
        sub_d   = sub_q;
        rcon_d  = rcon_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cur_d   = keyIn;
                    rnd_d   = 4'(Nr);
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (key_ready) begin
                    if (rnd_q == 4'd0) begin
                        state_d = FIN;
                    end else begin
`ifdef INV_KEY_SBOX_REG_EN
                        state_d = SUBW;
`else
                        state_d = STEP;
`endif
                    end
                end
            end
            SUBW: begin
`ifdef INV_KEY_SBOX_REG_EN
                sub_d  = sw;
                rcon_d = rcon_v;
`endif
                state_d = STEP;
            end
            STEP: begin
                cur_d   = prev;
                rnd_d   = 4'(rnd_q - 4'd1);
                state_d = EMIT;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        valid_d = (state_d == EMIT);
        last_d  = (state_d == EMIT) && (rnd_d == 4'd0);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == FIN);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
            rnd_q   <= 4'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef INV_KEY_SBOX_REG_EN
            sub_q   <= 32'h0;
            rcon_q  <= 8'h0;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rnd_q   <= rnd_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef INV_KEY_SBOX_REG_EN
            sub_q   <= sub_d;
            rcon_q  <= rcon_d;
`endif
        end
    end

    assign key_out   = cur_q;
    assign key_round = rnd_q;
    assign key_valid = valid_q;
    assign key_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Scoreboard bench for aes_inv_key_schedule.
// Reference: FIPS-197 KeyExpansion on a word array, run forwards and backwards.
module tb_aes_inv_key_schedule;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] keyIn;
    logic [127:0] key_out;
    logic [3:0]   key_round;
    logic         key_valid;
    logic         key_ready;
    logic         key_last;
    logic         busy;
    logic         done;

    aes_inv_key_schedule dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .keyIn     (keyIn),
        .key_out   (key_out),
        .key_round (key_round),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_last  (key_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

`ifdef INV_KEY_SBOX_REG_EN
    localparam int CPK = 3;
`else
    localparam int CPK = 2;
`endif
    localparam int EXP_LAT = 1 + 11 * CPK - (CPK - 1) + 1;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
        logic         last;
    } beat_t;

    beat_t        exp_q[$];
    int           checks = 0;
    int           failures = 0;
    int           done_cnt = 0;
    int           exp_done = 0;
    bit           bp_en = 0;
    bit           noise_en = 0;
    bit           xfer_seen = 0;
    int           stall_cnt = 0;
    logic [7:0]   sbox [256];
    logic [7:0]   rcon_t [11];
    logic [127:0] rk [11];
    logic [127:0] last0_key = '0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [31:0] subrot(input logic [31:0] x);
        logic [31:0] r;
        r = {x[23:0], x[31:24]};
        return {sbox[r[31:24]], sbox[r[23:16]], sbox[r[15:8]], sbox[r[7:0]]};
    endfunction

    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
        rcon_t = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                   8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    endtask

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = subrot(t) ^ {rcon_t[i/4], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic unexpand(input logic [127:0] k10);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[40+i] = k10[127-32*i -: 32];
        for (int i = 43; i >= 4; i--) begin
            t = w[i-1];
            if (i % 4 == 0) t = subrot(t) ^ {rcon_t[i/4], 24'h0};
            w[i-4] = w[i] ^ t;
        end
        for (int r = 0; r < 11; r++)
            rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic push_rk();
        beat_t b;
        for (int r = 10; r >= 0; r--) begin
            b.rnd  = 4'(r);
            b.key  = rk[r];
            b.last = (r == 0);
            exp_q.push_back(b);
        end
    endtask

    // Drives key_ready; with backpressure, stalls 0-5 cycles per beat
    initial begin
        key_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (xfer_seen && bp_en) stall_cnt = $urandom_range(0, 5);
            if (!bp_en) begin
                key_ready = 1'b1;
            end else if (stall_cnt > 0) begin
                key_ready = 1'b0;
                stall_cnt--;
            end else begin
                key_ready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every transferred beat
    initial begin
        logic [127:0] prev_key;
        logic [3:0]   prev_rnd;
        bit           stalled;
        bit           prev_done;
        beat_t        e;
        stalled   = 0;
        prev_done = 0;
        forever begin
            @(negedge clk);
            if (stalled) begin
                chk("stall_valid", 128'(key_valid), 128'(1'b1));
                chk("stall_key", key_out, prev_key);
                chk("stall_round", 128'(key_round), 128'(prev_rnd));
            end
            stalled   = (key_valid === 1'b1) && (key_ready === 1'b0);
            prev_key  = key_out;
            prev_rnd  = key_round;
            xfer_seen = (key_valid === 1'b1) && (key_ready === 1'b1);
            if (xfer_seen) begin
                chk("beat_busy", 128'(busy), 128'(1'b1));
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: round %0d key %h, none expected",
                             key_round, key_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_round", 128'(key_round), 128'(e.rnd));
                    chk("beat_key", key_out, e.key);
                    chk("beat_last", 128'(key_last), 128'(e.last));
                end
                if (key_round == 4'd0) last0_key = key_out;
            end
            if (done === 1'b1) begin
                done_cnt++;
                chk("done_width", 128'(prev_done), 128'(1'b0));
            end
            prev_done = (done === 1'b1);
        end
    end

    task automatic run_seq(input bit chk_lat);
        int cyc;
        push_rk();
        @(posedge clk);
        #1;
        start = 1'b1;
        keyIn = rk[10];
        cyc = 0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) break;
            if (cyc > 400) begin
                checks++;
                failures++;
                $display("FAIL seq_timeout: no done after %0d cycles, want done", cyc);
                exp_q.delete();
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
            start = noise_en && ($urandom_range(0, 3) == 0 || key_round == 4'd5);
            keyIn = rnd128();
        end
        start = 1'b0;
        exp_done++;
        chk("seq_drained", 128'(exp_q.size()), 128'(0));
        if (chk_lat) chk("latency", 128'(cyc + 1), 128'(EXP_LAT));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_key_out"}, key_out, 128'h0);
        chk({tag, "_round"}, 128'(key_round), 128'(0));
        chk({tag, "_valid"}, 128'(key_valid), 128'(0));
        chk({tag, "_last"}, 128'(key_last), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
    endtask

    task automatic reset_mid_seq();
        int cyc;
        expand(rnd128());
        push_rk();
        @(posedge clk);
        #1;
        start = 1'b1;
        keyIn = rk[10];
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (key_valid === 1'b1 && key_round == 4'd4) break;
            cyc++;
            if (cyc > 200) begin
                checks++;
                failures++;
                $display("FAIL reach_round4: not seen in %0d cycles, want round 4", cyc);
                break;
            end
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_idle("midreset");
        repeat (4) @(negedge clk);
        chk("midreset_no_done", 128'(done_cnt), 128'(exp_done));
    endtask

    initial begin
        build_sbox();
        reset = 1'b1;
        start = 1'b0;
        keyIn = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        run_seq(1'b1);

        noise_en = 1;
        for (int i = 0; i < 3; i++) begin
            expand(rnd128());
            run_seq(1'b1);
        end
        noise_en = 0;

        bp_en = 1;
        for (int i = 0; i < 5; i++) begin
            expand(rnd128());
            run_seq(1'b0);
        end
        bp_en = 0;

        reset_mid_seq();
        unexpand(128'h0);
        run_seq(1'b1);
        expand(last0_key);
        chk("zero_key_roundtrip", rk[10], 128'h0);

        for (int i = 0; i < 100; i++) begin
            bp_en    = ($urandom_range(0, 3) == 0);
            noise_en = ($urandom_range(0, 1) == 1);
            expand(rnd128());
            run_seq(!bp_en);
        end
        bp_en    = 0;
        noise_en = 0;

        repeat (3) @(negedge clk);
        chk("done_total", 128'(done_cnt), 128'(exp_done));
        chk("final_queue", 128'(exp_q.size()), 128'(0));
        chk("final_idle", 128'(busy), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
